iram_axi_arb: RTL and testbench



---
 rtl/iram_axi_arb.sv | 206 ++++++++++++++++++++
 tb/tb_iram_axi_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_axi_arb.sv
// iram_axi_arb
//   Two-master AXI4-Lite arbiter in front of the instruction RAM's port b.
//   Master 0 is the core load/store path and master 1 is the debug/program
//   loader. An accepted transaction owns the slave until its response
//   handshake completes. Masters are served round-robin. Within one master,
//   a write is served before a read.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   mN_aw*/w*/b*/ar*/r*    AXI4-Lite slave-facing channels of master N (N = 0, 1)
//   s_aw*/w*/b*/ar*/r*     AXI4-Lite master-facing channels toward the iram
//   gnt_o                  one-hot current owner, 00 when idle
//   busy_o                 a transaction is in flight
module iram_axi_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // master 0
  input  logic [AW-1:0]   m0_awaddr,
  input  logic [2:0]      m0_awprot,
  input  logic            m0_awvalid,
  output logic            m0_awready,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic            m0_wvalid,
  output logic            m0_wready,
  output logic [1:0]      m0_bresp,
  output logic            m0_bvalid,
  input  logic            m0_bready,
  input  logic [AW-1:0]   m0_araddr,
  input  logic [2:0]      m0_arprot,
  input  logic            m0_arvalid,
  output logic            m0_arready,
  output logic [DW-1:0]   m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  // master 1
  input  logic [AW-1:0]   m1_awaddr,
  input  logic [2:0]      m1_awprot,
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  output logic [1:0]      m1_bresp,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  input  logic [AW-1:0]   m1_araddr,
  input  logic [2:0]      m1_arprot,
  input  logic            m1_arvalid,
  output logic            m1_arready,
  output logic [DW-1:0]   m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  // iram slave
  output logic [AW-1:0]   s_awaddr,
  output logic [2:0]      s_awprot,
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  output logic            s_wvalid,
  input  logic            s_wready,
  input  logic [1:0]      s_bresp,
  input  logic            s_bvalid,
  output logic            s_bready,
  output logic [AW-1:0]   s_araddr,
  output logic [2:0]      s_arprot,
  output logic            s_arvalid,
  input  logic            s_arready,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic            s_rvalid,
  output logic            s_rready,
  // status
  output logic [1:0]      gnt_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RRESP = 3'd4
  } state_t;

  state_t     state_r;
  logic       owner_r;     // 0 = master 0, 1 = master 1
  logic       last_gnt_r;  // master granted most recently
  logic [1:0] gnt_r;
  logic       busy_r;

  logic wreq0_s, wreq1_s, req0_s, req1_s;
  logic win_s, win_wreq_s;
  logic in_waddr_s, in_wresp_s, in_raddr_s, in_rresp_s;

  assign wreq0_s = m0_awvalid & m0_wvalid;
  assign wreq1_s = m1_awvalid & m1_wvalid;
  assign req0_s  = wreq0_s | m0_arvalid;
  assign req1_s  = wreq1_s | m1_arvalid;

  // Round-robin winner: on a tie the master that was not granted last wins
  always_comb begin
    win_s = 1'b0;
    if (req0_s & req1_s) begin
      win_s = ~last_gnt_r;
    end else if (req1_s) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    win_wreq_s = win_s ? wreq1_s : wreq0_s;
  end

  // Transaction sequencer: grant, address phase, response phase, back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      owner_r    <= 1'b0;
      last_gnt_r <= 1'b1;
      gnt_r      <= 2'b00;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0_s | req1_s) begin
            owner_r    <= win_s;
            last_gnt_r <= win_s;
            gnt_r      <= win_s ? 2'b10 : 2'b01;
            busy_r     <= 1'b1;
            state_r    <= win_wreq_s ? WADDR : RADDR;
          end
        end
        // Address and data must be taken together; the owner keeps both valid
        WADDR: if (s_awready & s_wready) state_r <= WRESP;
        WRESP: begin
          if (s_bvalid & s_bready) begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
            busy_r  <= 1'b0;
          end
        end
        RADDR: if (s_arready) state_r <= RRESP;
        RRESP: begin
          if (s_rvalid & s_rready) begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 2'b00;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_waddr_s = (state_r == WADDR);
  assign in_wresp_s = (state_r == WRESP);
  assign in_raddr_s = (state_r == RADDR);
  assign in_rresp_s = (state_r == RRESP);

  // Payload toward the slave follows the registered owner only
  assign s_awaddr  = owner_r ? m1_awaddr : m0_awaddr;
  assign s_awprot  = owner_r ? m1_awprot : m0_awprot;
  assign s_wdata   = owner_r ? m1_wdata  : m0_wdata;
  assign s_wstrb   = owner_r ? m1_wstrb  : m0_wstrb;
  assign s_araddr  = owner_r ? m1_araddr : m0_araddr;
  assign s_arprot  = owner_r ? m1_arprot : m0_arprot;
  assign s_awvalid = in_waddr_s;
  assign s_wvalid  = in_waddr_s;
  assign s_arvalid = in_raddr_s;
  assign s_bready  = in_wresp_s & (owner_r ? m1_bready : m0_bready);
  assign s_rready  = in_rresp_s & (owner_r ? m1_rready : m0_rready);

  // Handshake returns are gated to the owner; response payload is broadcast
  assign m0_awready = in_waddr_s & ~owner_r & s_awready;
  assign m0_wready  = in_waddr_s & ~owner_r & s_wready;
  assign m0_bvalid  = in_wresp_s & ~owner_r & s_bvalid;
  assign m0_arready = in_raddr_s & ~owner_r & s_arready;
  assign m0_rvalid  = in_rresp_s & ~owner_r & s_rvalid;
  assign m1_awready = in_waddr_s &  owner_r & s_awready;
  assign m1_wready  = in_waddr_s &  owner_r & s_wready;
  assign m1_bvalid  = in_wresp_s &  owner_r & s_bvalid;
  assign m1_arready = in_raddr_s &  owner_r & s_arready;
  assign m1_rvalid  = in_rresp_s &  owner_r & s_rvalid;

  assign m0_bresp = s_bresp;
  assign m1_bresp = s_bresp;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;

  assign gnt_o  = gnt_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_iram_axi_arb.sv
// Testbench for iram_axi_arb: directed master traffic against a small iram
// slave model, with a scoreboard monitor that checks responses and grants.
module tb_iram_axi_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // master-side stimulus / observation, index = master number
  logic [AW-1:0] awaddr [2];
  logic [2:0]    awprot [2];
  logic          awvalid[2];
  logic          awready[2];
  logic [DW-1:0] wdata  [2];
  logic [3:0]    wstrb  [2];
  logic          wvalid [2];
  logic          wready [2];
  logic [1:0]    bresp  [2];
  logic          bvalid [2];
  logic          bready [2];
  logic [AW-1:0] araddr [2];
  logic [2:0]    arprot [2];
  logic          arvalid[2];
  logic          arready[2];
  logic [DW-1:0] rdata  [2];
  logic [1:0]    rresp  [2];
  logic          rvalid [2];
  logic          rready [2];

  logic [AW-1:0] s_awaddr, s_araddr;
  logic [2:0]    s_awprot, s_arprot;
  logic          s_awvalid, s_awready, s_wvalid, s_wready;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [3:0]    s_wstrb;
  logic [1:0]    s_bresp, s_rresp;
  logic          s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]    gnt_o;
  logic          busy_o;

  iram_axi_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_awaddr(awaddr[0]), .m0_awprot(awprot[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
    .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
    .m0_araddr(araddr[0]), .m0_arprot(arprot[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
    .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
    .m1_awaddr(awaddr[1]), .m1_awprot(awprot[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
    .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
    .m1_araddr(araddr[1]), .m1_arprot(arprot[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
    .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  // iram slave model: aw/w/ar ready while no response is pending, registered responses
  logic [31:0] mem [16];
  assign s_awready = ~s_bvalid;
  assign s_wready  = ~s_bvalid;
  assign s_arready = ~s_rvalid;
  assign s_bresp   = 2'b00;
  assign s_rresp   = 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= 32'h0;
    end else begin
      if (s_awvalid && s_wvalid && s_awready && s_wready) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        s_bvalid <= 1'b1;
      end else if (s_bready) begin
        s_bvalid <= 1'b0;
      end
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[s_araddr[5:2]];
      end else if (s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard queues
  logic [1:0]  exp_g_q[$];
  logic [1:0]  exp_b0_q[$];
  logic [1:0]  exp_b1_q[$];
  logic [31:0] exp_r0_q[$];
  logic [31:0] exp_r1_q[$];
  logic [1:0]  prev_gnt = 2'b00;

  // monitor: pops expectations whenever the DUT presents a response or a new grant
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid[0] && bready[0]) begin
        if (exp_b0_q.size() == 0) check("m0_unexpected_b", 32'd1, 32'd0);
        else check("m0_bresp", 32'(bresp[0]), 32'(exp_b0_q.pop_front()));
      end
      if (bvalid[1] && bready[1]) begin
        if (exp_b1_q.size() == 0) check("m1_unexpected_b", 32'd1, 32'd0);
        else check("m1_bresp", 32'(bresp[1]), 32'(exp_b1_q.pop_front()));
      end
      if (rvalid[0] && rready[0]) begin
        if (exp_r0_q.size() == 0) check("m0_unexpected_r", 32'd1, 32'd0);
        else begin
          check("m0_rdata", rdata[0], exp_r0_q.pop_front());
          check("m0_rresp", 32'(rresp[0]), 32'd0);
        end
      end
      if (rvalid[1] && rready[1]) begin
        if (exp_r1_q.size() == 0) check("m1_unexpected_r", 32'd1, 32'd0);
        else begin
          check("m1_rdata", rdata[1], exp_r1_q.pop_front());
          check("m1_rresp", 32'(rresp[1]), 32'd0);
        end
      end
      if (gnt_o != 2'b01)
        check("m0_nonowner_quiet", 32'({awready[0], wready[0], arready[0], bvalid[0], rvalid[0]}), 32'd0);
      if (gnt_o != 2'b10)
        check("m1_nonowner_quiet", 32'({awready[1], wready[1], arready[1], bvalid[1], rvalid[1]}), 32'd0);
      if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
        if (exp_g_q.size() == 0) check("unexpected_grant", 32'(gnt_o), 32'd0);
        else check("grant_order", 32'(gnt_o), 32'(exp_g_q.pop_front()));
      end
      if (gnt_o != 2'b00 && prev_gnt != 2'b00 && gnt_o != prev_gnt)
        check("grant_without_idle", 32'(gnt_o), 32'(prev_gnt));
    end
    prev_gnt <= gnt_o;
  end

  task automatic clear_masters();
    for (int n = 0; n < 2; n++) begin
      awaddr[n] = '0; awprot[n] = 3'b000; awvalid[n] = 1'b0;
      wdata[n] = '0; wstrb[n] = 4'h0; wvalid[n] = 1'b0; bready[n] = 1'b1;
      araddr[n] = '0; arprot[n] = 3'b000; arvalid[n] = 1'b0; rready[n] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_masters();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_aw(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    awaddr[n] = a; wdata[n] = d; wstrb[n] = s; awvalid[n] = 1'b1; wvalid[n] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (awready[n] && wready[n]) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1 awvalid[n] = 1'b0; wvalid[n] = 1'b0;
    if (!ok) check("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_ar(input int n, input logic [31:0] a);
    bit ok = 1'b0;
    araddr[n] = a; arvalid[n] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arready[n]) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1 arvalid[n] = 1'b0;
    if (!ok) check("ar_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_o && exp_g_q.size() == 0 && exp_b0_q.size() == 0 && exp_b1_q.size() == 0 &&
          exp_r0_q.size() == 0 && exp_r1_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_m_outs", 32'({awready[0], wready[0], arready[0], bvalid[0], rvalid[0],
                             awready[1], wready[1], arready[1], bvalid[1], rvalid[1]}), 32'd0);
    check("rst_s_valids", 32'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 32'd0);
    @(posedge clk);
    #1;

    // single m0 write with cycle-exact timing
    exp_g_q.push_back(2'b01);
    exp_b0_q.push_back(2'b00);
    awaddr[0] = 32'h10; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF; awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    @(negedge clk);
    check("t0_s_awvalid", 32'(s_awvalid), 32'd0);
    @(negedge clk);
    check("t1_s_awvalid", 32'({s_awvalid, s_wvalid}), 32'd3);
    check("t1_s_awaddr", s_awaddr, 32'h10);
    check("t1_s_awprot", 32'(s_awprot), 32'd0);
    check("t1_s_wdata", s_wdata, 32'hDEADBEEF);
    check("t1_s_wstrb", 32'(s_wstrb), 32'hF);
    check("t1_gnt", 32'(gnt_o), 32'd1);
    check("t1_m0_ready", 32'({awready[0], wready[0]}), 32'd3);
    @(posedge clk);
    #1 awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(negedge clk);
    check("t2_m0_bvalid", 32'(bvalid[0]), 32'd1);
    @(negedge clk);
    check("t3_busy", 32'(busy_o), 32'd0);
    check("t3_gnt", 32'(gnt_o), 32'd0);
    drain();

    // simultaneous m0 write and m1 read right after reset: m0 first
    do_reset();
    exp_g_q.push_back(2'b01);
    exp_g_q.push_back(2'b10);
    exp_b0_q.push_back(2'b00);
    exp_r1_q.push_back(32'hCAFEF00D);
    fork
      do_aw(0, 32'h20, 32'hCAFEF00D, 4'hF);
      do_ar(1, 32'h20);
    join
    drain();

    // both masters request continuously: grants alternate
    for (int i = 0; i < 4; i++) begin
      exp_g_q.push_back(2'b01);
      exp_g_q.push_back(2'b10);
      exp_b0_q.push_back(2'b00);
      exp_r1_q.push_back(i[0] ? 32'hCAFEF00D : 32'hDEADBEEF);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) do_aw(0, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF);
      end
      begin
        for (int i = 0; i < 4; i++) do_ar(1, i[0] ? 32'h20 : 32'h10);
      end
    join
    drain();

    // m1 write and read together: write first, read sees new data
    exp_g_q.push_back(2'b10);
    exp_g_q.push_back(2'b10);
    exp_b1_q.push_back(2'b00);
    exp_r1_q.push_back(32'h12345678);
    fork
      do_aw(1, 32'h30, 32'h12345678, 4'hF);
      do_ar(1, 32'h30);
    join
    drain();

    // partial-strobe write then read back, plus readback of the streamed writes
    exp_g_q.push_back(2'b01);
    exp_g_q.push_back(2'b01);
    exp_g_q.push_back(2'b01);
    exp_b0_q.push_back(2'b00);
    exp_r0_q.push_back(32'h1234FFFF);
    exp_r0_q.push_back(32'hA0000003);
    do_aw(0, 32'h30, 32'hFFFFFFFF, 4'h3);
    do_ar(0, 32'h30);
    do_ar(0, 32'h4C);
    drain();

    // m0 read stalled on rready, reset during RRESP aborts it
    exp_g_q.push_back(2'b01);
    araddr[0] = 32'h10; arvalid[0] = 1'b1; rready[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rd_s_arvalid", 32'(s_arvalid), 32'd1);
    check("rd_s_araddr", s_araddr, 32'h10);
    check("rd_s_arprot", 32'(s_arprot), 32'd0);
    @(posedge clk);
    #1 arvalid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("stall_rvalid", 32'(rvalid[0]), 32'd1);
    check("stall_busy", 32'(busy_o), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_gnt", 32'(gnt_o), 32'd0);
    check("abort_rvalid", 32'(rvalid[0]), 32'd0);
    rst = 1'b0;
    rready[0] = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
